// File: rtl/awg_seq_index_receiver.sv
// AWG-side receiver for the Data_Select-framed serial sequencer-index load.
// Oversamples ser_clk/ser_data/ser_load on clk and assembles a 19-bit index.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ser_clk      serial bit strobe (data valid at its rising edge)
//   ser_data     serial data: Data_Select first, then index bits MSB-first
//   ser_load     load strobe; its rising edge ends a frame
//   seq_index    last committed index {hi_reg, lo}
//   index_valid  one-cycle pulse when seq_index updates
//   hi_valid     hi_reg written since reset or the last index commit
//   frame_err    one-cycle pulse when a frame is discarded
//   busy         a frame is partially shifted
module awg_seq_index_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int HI_WIDTH    = 6,
    parameter int LO_WIDTH    = 13
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ser_clk,
    input  logic                         ser_data,
    input  logic                         ser_load,
    output logic [HI_WIDTH+LO_WIDTH-1:0] seq_index,
    output logic                         index_valid,
    output logic                         hi_valid,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int SW = LO_WIDTH + 1;
    localparam logic [4:0] CNT_MAX = 5'(LO_WIDTH + 2);
    localparam logic [4:0] CNT_HI  = 5'(HI_WIDTH + 1);
    localparam logic [4:0] CNT_LO  = 5'(LO_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic [SYNC_STAGES-1:0] ld_sync_q;
    logic                   clk_prev_q;
    logic                   ld_prev_q;

    state_t                        state_q;
    logic [SW-1:0]                 shreg_q;
    logic [4:0]                    bit_cnt_q;
    logic                          ovf_q;
    logic [HI_WIDTH-1:0]           hi_reg_q;
    logic [HI_WIDTH+LO_WIDTH-1:0]  seq_index_q;
    logic                          index_valid_q;
    logic                          hi_valid_q;
    logic                          frame_err_q;

    logic clk_s;
    logic dat_s;
    logic ld_s;
    logic shift_en;
    logic load_en;

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign dat_s    = dat_sync_q[SYNC_STAGES-1];
    assign ld_s     = ld_sync_q[SYNC_STAGES-1];
    assign shift_en = clk_s & ~clk_prev_q;
    assign load_en  = ld_s & ~ld_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            ld_sync_q  <= '0;
            clk_prev_q <= 1'b0;
            ld_prev_q  <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ser_data};
            ld_sync_q  <= {ld_sync_q[SYNC_STAGES-2:0], ser_load};
            clk_prev_q <= clk_s;
            ld_prev_q  <= ld_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            ovf_q         <= 1'b0;
            hi_reg_q      <= '0;
            seq_index_q   <= '0;
            index_valid_q <= 1'b0;
            hi_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            index_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A lone load_en here is a zero-bit frame and is ignored.
                    if (shift_en) begin
                        shreg_q   <= {shreg_q[SW-2:0], dat_s};
                        bit_cnt_q <= 5'd1;
                        state_q   <= load_en ? COMMIT : SHIFT;
                    end
                end
                SHIFT: begin
                    // Same-cycle shift and load: the bit still counts.
                    if (shift_en) begin
                        shreg_q <= {shreg_q[SW-2:0], dat_s};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                        if (bit_cnt_q >= CNT_LO) begin
                            ovf_q <= 1'b1;
                        end
                    end
                    if (load_en) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    // A bit arriving now cannot be kept, so the frame is bad.
                    if (ovf_q || shift_en) begin
                        frame_err_q <= 1'b1;
                    end else if (bit_cnt_q == CNT_HI && shreg_q[HI_WIDTH]) begin
                        hi_reg_q   <= shreg_q[HI_WIDTH-1:0];
                        hi_valid_q <= 1'b1;
                    end else if (bit_cnt_q == CNT_LO && !shreg_q[LO_WIDTH]) begin
                        seq_index_q   <= {hi_reg_q, shreg_q[LO_WIDTH-1:0]};
                        index_valid_q <= 1'b1;
                        hi_valid_q    <= 1'b0;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    ovf_q     <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign seq_index   = seq_index_q;
    assign index_valid = index_valid_q;
    assign hi_valid    = hi_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (bit_cnt_q != 5'd0);

endmodule

// File: tb/tb_awg_seq_index_receiver.sv
// Bench for awg_seq_index_receiver: frame table, corner sequences and
// random frames checked against a bit-list reference model.
module tb_awg_seq_index_receiver;

    logic        clk;
    logic        rst_n;
    logic        ser_clk;
    logic        ser_data;
    logic        ser_load;
    logic [18:0] seq_index;
    logic        index_valid;
    logic        hi_valid;
    logic        frame_err;
    logic        busy;

    awg_seq_index_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_clk     (ser_clk),
        .ser_data    (ser_data),
        .ser_load    (ser_load),
        .seq_index   (seq_index),
        .index_valid (index_valid),
        .hi_valid    (hi_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int iv_cyc = 0;
    int err_cyc = 0;

    // Count high cycles of the pulse outputs; a stretched pulse shows up.
    always @(negedge clk) begin
        if (index_valid === 1'b1) iv_cyc++;
        if (frame_err === 1'b1) err_cyc++;
    end

    // Reference model: frame = list of received bits, first is Data_Select.
    logic [5:0]  m_hi;
    logic [18:0] m_idx;
    logic        m_hv;

    task automatic model_reset();
        m_hi  = '0;
        m_idx = '0;
        m_hv  = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] bits, input int n,
                               output int e_iv, output int e_err);
        bit q[$];
        int lo;
        e_iv  = 0;
        e_err = 0;
        for (int i = n - 1; i >= 0; i--) q.push_back(bits[i]);
        if (q.size() == 0) return;
        if (q.size() == 7 && q[0] == 1'b1) begin
            m_hi = '0;
            for (int i = 1; i < 7; i++) m_hi = m_hi * 2 + 6'(q[i]);
            m_hv = 1'b1;
        end else if (q.size() == 14 && q[0] == 1'b0) begin
            lo = 0;
            for (int i = 1; i < 14; i++) lo = lo * 2 + int'(q[i]);
            m_idx = 19'(int'(m_hi) * 8192 + lo);
            m_hv  = 1'b0;
            e_iv  = 1;
        end else begin
            e_err = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int hold);
        ser_data = b;
        wait_n(hold);
        ser_clk = 1'b1;
        wait_n(hold);
        ser_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int hi_i,
                             input int lo_i, input int hold);
        for (int i = hi_i; i >= lo_i; i--) send_bit(bits[i], hold);
    endtask

    task automatic pulse_load(input int hold);
        ser_load = 1'b1;
        wait_n(hold);
        ser_load = 1'b0;
        wait_n(hold + 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_seq_index", 32'(seq_index), 32'h0);
        chk("rst_hi_valid", 32'(hi_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pulses", 32'({index_valid, frame_err}), 32'h0);
        wait_n(2);
        rst_n = 1'b1;
        model_reset();
        wait_n(2);
    endtask

    task automatic check_frame(input string tag, input int iv0, input int er0,
                               input logic [18:0] e_idx, input logic e_hv,
                               input int e_iv, input int e_err);
        chk({tag, "_seq_index"}, 32'(seq_index), 32'(e_idx));
        chk({tag, "_hi_valid"}, 32'(hi_valid), 32'(e_hv));
        chk({tag, "_iv_cycles"}, 32'(iv_cyc - iv0), 32'(e_iv));
        chk({tag, "_err_cycles"}, 32'(err_cyc - er0), 32'(e_err));
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    typedef struct {
        logic        rst;
        logic [15:0] bits;
        int          n;
        logic [18:0] e_idx;
        logic        e_hv;
        int          e_iv;
        int          e_err;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int iv0;
        int er0;
        int e_iv;
        int e_err;
        int hold;
        logic [15:0] bits;
        int n;
        int r;

        tbl[0]  = '{1'b1, 16'h006D, 7,  19'h00000, 1'b1, 0, 0};
        tbl[1]  = '{1'b0, 16'h05A5, 14, 19'h5A5A5, 1'b0, 1, 0};
        tbl[2]  = '{1'b0, 16'h0000, 0,  19'h5A5A5, 1'b0, 0, 0};
        tbl[3]  = '{1'b1, 16'h1FFF, 14, 19'h01FFF, 1'b0, 1, 0};
        tbl[4]  = '{1'b0, 16'h0036, 6,  19'h01FFF, 1'b0, 0, 1};
        tbl[5]  = '{1'b0, 16'hF0F0, 16, 19'h01FFF, 1'b0, 0, 1};
        tbl[6]  = '{1'b0, 16'h0001, 14, 19'h00001, 1'b0, 1, 0};
        tbl[7]  = '{1'b0, 16'h002A, 7,  19'h00001, 1'b0, 0, 1};
        tbl[8]  = '{1'b0, 16'h007F, 7,  19'h00001, 1'b1, 0, 0};
        tbl[9]  = '{1'b0, 16'h0002, 14, 19'h7E002, 1'b0, 1, 0};
        tbl[10] = '{1'b0, 16'h0003, 14, 19'h7E003, 1'b0, 1, 0};

        rst_n    = 1'b0;
        ser_clk  = 1'b0;
        ser_data = 1'b0;
        ser_load = 1'b0;
        model_reset();
        wait_n(3);
        rst_n = 1'b1;
        wait_n(2);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            iv0 = iv_cyc;
            er0 = err_cyc;
            send_bits(tbl[i].bits, tbl[i].n - 1, 0, 3);
            pulse_load(3);
            model_frame(tbl[i].bits, tbl[i].n, e_iv, e_err);
            check_frame($sformatf("tbl%0d", i), iv0, er0, tbl[i].e_idx,
                        tbl[i].e_hv, tbl[i].e_iv, tbl[i].e_err);
        end

        // Reset in the middle of a frame drops it at once.
        send_bits(16'h0ABC, 13, 6, 3);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_seq_index", 32'(seq_index), 32'h0);
        chk("midrst_hi_valid", 32'(hi_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_n(2);

        // Fresh frame after reset, plus load-to-index_valid latency.
        iv0 = iv_cyc;
        er0 = err_cyc;
        send_bits(16'h0ABC, 13, 0, 3);
        @(negedge clk);
        ser_load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("lat_iv_early", 32'(index_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_iv_on_time", 32'(index_valid), 32'h1);
        @(negedge clk);
        wait_n(2);
        ser_load = 1'b0;
        wait_n(6);
        model_frame(16'h0ABC, 14, e_iv, e_err);
        check_frame("after_rst", iv0, er0, 19'h00ABC, 1'b0, 1, 0);

        // Last bit's ser_clk rise and the ser_load rise land together.
        iv0 = iv_cyc;
        er0 = err_cyc;
        send_bits(16'h1234, 13, 1, 3);
        ser_data = 1'b0;
        wait_n(3);
        ser_clk  = 1'b1;
        ser_load = 1'b1;
        wait_n(4);
        ser_clk  = 1'b0;
        ser_load = 1'b0;
        wait_n(6);
        model_frame(16'h1234, 14, e_iv, e_err);
        check_frame("same_cycle", iv0, er0, 19'h01234, 1'b0, 1, 0);

        // Random frames against the model.
        for (int k = 0; k < 40; k++) begin
            r    = int'($urandom_range(0, 9));
            bits = 16'($urandom);
            hold = int'($urandom_range(3, 5));
            if (r < 4) begin
                n = 7;
                bits[6] = 1'b1;
            end else if (r < 8) begin
                n = 14;
                bits[13] = 1'b0;
            end else begin
                n = int'($urandom_range(0, 16));
            end
            iv0 = iv_cyc;
            er0 = err_cyc;
            send_bits(bits, n - 1, 0, hold);
            pulse_load(hold);
            model_frame(bits, n, e_iv, e_err);
            check_frame($sformatf("rnd%0d", k), iv0, er0, m_idx, m_hv,
                        e_iv, e_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
